// File: rtl/adder_result_checker_if.sv
// Beat bus between an adder-under-test harness and adder_result_checker.
// master drives one beat {x, y, s, cout} qualified by in_valid.
// slave returns in_ready.
// A beat transfers on a clock edge where in_valid && in_ready.
//   in_valid  master->slave  x/y/s/cout hold a beat
//   in_ready  slave->master  checker accepts a beat this cycle
//   x, y      master->slave  adder operands (WIDTH bits)
//   s, cout   master->slave  adder result under test
interface adder_result_checker_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output in_valid, x, y, s, cout, input in_ready);
  modport slave  (input in_valid, x, y, s, cout, output in_ready);
endinterface

// File: rtl/adder_result_checker.sv
// In-line result checker for a WIDTH-bit adder.
// Each accepted beat is compared against a golden x+y one cycle later.
// Mismatches are counted, and the first failing beat's 1-based index is kept.
// pass/fail is reported after N_VECTORS beats.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start          one-cycle pulse arming a run (honoured in IDLE/DONE only)
//   bus            beat bus (slave side): in_valid/x/y/s/cout in, in_ready out
//   busy           run in progress (RUN or FLUSH)
//   done           run complete, results stable
//   pass           done with zero mismatches
//   err_pulse      one-cycle pulse per mismatching beat
//   vec_count      beats accepted this run
//   err_count      mismatches this run, saturating
//   first_err_idx  1-based index of the first mismatch, 0 = none
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting beats, one per cycle
// FLUSH | last beat accepted, its comparison retires
// DONE  | results held until start or rst
module adder_result_checker #(
  parameter int WIDTH     = 6,
  parameter int N_VECTORS = 4096,
  parameter int CNT_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_result_checker_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic [WIDTH:0]   golden_q, golden_d;
  logic [WIDTH:0]   dut_q, dut_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             accept;
  logic             mismatch;
  logic             arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      vec_count_q     <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      golden_q        <= '0;
      dut_q           <= '0;
      cmp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      vec_count_q     <= vec_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      golden_q        <= golden_d;
      dut_q           <= dut_d;
      cmp_valid_q     <= cmp_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    vec_count_d     = vec_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    golden_d        = golden_q;
    dut_d           = dut_q;
    cmp_valid_d     = 1'b0;

    accept   = bus.in_valid && (state_q == RUN);
    // cmp_valid_q marks that golden_q/dut_q hold the beat accepted last cycle
    mismatch = cmp_valid_q && (golden_q != dut_q);
    arm      = start && ((state_q == IDLE) || (state_q == DONE));

    // vec_count_q already holds the compared beat's index, even if a new
    // beat is being accepted in the same cycle
    if (mismatch) begin
      if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
      if (first_err_idx_q == '0)  first_err_idx_d = vec_count_q;
    end

    if (accept) begin
      golden_d    = {1'b0, bus.x} + {1'b0, bus.y};
      dut_d       = {bus.cout, bus.s};
      cmp_valid_d = 1'b1;
      vec_count_d = vec_count_q + CNT_W'(1);
    end

    // arm only happens in IDLE/DONE, where no comparison is in flight
    if (arm) begin
      vec_count_d     = '0;
      err_count_d     = '0;
      first_err_idx_d = '0;
    end

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (vec_count_q == LAST_IDX)) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == RUN);
  assign busy            = (state_q == RUN) || (state_q == FLUSH);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && (err_count_q == '0);
  assign err_pulse       = mismatch;
  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;
  localparam int WIDTH     = 6;
  localparam int N_VECTORS = 4096;
  localparam int CNT_W     = 13;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, err_pulse;
  logic [CNT_W-1:0] vec_count, err_count, first_err_idx;

  int checks = 0;
  int passed = 0;

  adder_result_checker_if #(.WIDTH(WIDTH)) bus ();

  adder_result_checker #(
    .WIDTH(WIDTH), .N_VECTORS(N_VECTORS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
    .vec_count(vec_count), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Reference model: tracks a run as counts of accepted beats and errors.
  // A run is "armed" by start when none is active; it accepts beats until
  // N_VECTORS have been taken; each beat's verdict is reported one edge
  // later; results are final one edge after the last beat.
  bit m_armed = 1'b0;
  int m_acc = 0;
  int m_err = 0;
  int m_first = 0;
  int m_post = 0;
  bit m_pend_mis = 1'b0;
  int m_pend_idx = 0;
  bit mw_done, mw_ready;
  int m_sum, m_got;

  function automatic bit m_done();
    return m_armed && (m_acc == N_VECTORS) && (m_post >= 1);
  endfunction

  function automatic bit m_ready();
    return m_armed && (m_acc < N_VECTORS);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed = 0; m_acc = 0; m_err = 0; m_first = 0; m_post = 0;
      m_pend_mis = 0; m_pend_idx = 0;
    end else begin
      mw_done  = m_done();
      mw_ready = m_ready();
      if (m_pend_mis) begin
        if (m_err < SAT) m_err++;
        if (m_first == 0) m_first = m_pend_idx;
      end
      m_pend_mis = 0;
      if (m_armed && m_acc == N_VECTORS && m_post < 1) m_post++;
      if (mw_ready && bus.in_valid) begin
        m_acc++;
        m_sum = int'(bus.x) + int'(bus.y);
        m_got = int'({bus.cout, bus.s});
        m_pend_mis = (m_sum != m_got);
        m_pend_idx = m_acc;
      end
      if (start && (!m_armed || mw_done)) begin
        m_armed = 1; m_acc = 0; m_err = 0; m_first = 0; m_post = 0;
      end
    end
  end

  // Advance to the next falling edge; inputs set before this are sampled
  // on the rising edge in between.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Drive one beat; bad corrupts {cout,s} with a random nonzero mask.
  task automatic set_beat(input bit v, input logic [WIDTH-1:0] xv,
                          input logic [WIDTH-1:0] yv, input bit bad);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] mask;
    sum  = {1'b0, xv} + {1'b0, yv};
    mask = (WIDTH+1)'($urandom_range(1, (1 << (WIDTH+1)) - 1));
    if (bad) sum = sum ^ mask;
    bus.in_valid = v;
    bus.x = xv;
    bus.y = yv;
    {bus.cout, bus.s} = sum;
  endtask

  task automatic test_reset();
    set_beat(0, '0, '0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else passed++;
    checks++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse got %b want 0", err_pulse); else passed++;
    checks++; if (vec_count !== '0) $display("FAIL reset_vec_count got %0d want 0", vec_count); else passed++;
    checks++; if (err_count !== '0) $display("FAIL reset_err_count got %0d want 0", err_count); else passed++;
    checks++; if (first_err_idx !== '0) $display("FAIL reset_first_err_idx got %0d want 0", first_err_idx); else passed++;
  endtask

  task automatic test_clean_run();
    pulse_start();
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL clean_ready_after_start got %b want 1", bus.in_ready); else passed++;
    for (int i = 0; i < N_VECTORS; i++) begin
      set_beat(1, WIDTH'(i >> WIDTH), WIDTH'(i), 0);
      cyc();
      checks++; if (err_pulse !== 1'b0) $display("FAIL clean_err_pulse beat %0d got %b want 0", i + 1, err_pulse); else passed++;
      checks++; if (vec_count !== CNT_W'(m_acc)) $display("FAIL clean_vec_count got %0d want %0d", vec_count, m_acc); else passed++;
    end
    set_beat(0, '0, '0, 0);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL clean_flush_ready got %b want 0", bus.in_ready); else passed++;
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL clean_flush_busy got busy=%b done=%b want busy=1 done=0", busy, done); else passed++;
    cyc();
    checks++; if (done !== 1'b1) $display("FAIL clean_done got %b want 1", done); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL clean_pass got %b want 1", pass); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL clean_busy got %b want 0", busy); else passed++;
    checks++; if (err_count !== '0) $display("FAIL clean_err_count got %0d want 0", err_count); else passed++;
    checks++; if (first_err_idx !== '0) $display("FAIL clean_first_err_idx got %0d want 0", first_err_idx); else passed++;
    checks++; if (vec_count !== CNT_W'(N_VECTORS)) $display("FAIL clean_vec_count_final got %0d want %0d", vec_count, N_VECTORS); else passed++;
    repeat (3) cyc();
    checks++; if (done !== 1'b1 || vec_count !== CNT_W'(N_VECTORS)) $display("FAIL clean_hold got done=%b vec=%0d want done=1 vec=%0d", done, vec_count, N_VECTORS); else passed++;
  endtask

  task automatic test_single_fault();
    pulse_start();
    checks++; if (vec_count !== '0 || done !== 1'b0) $display("FAIL fault_restart_clear got vec=%0d done=%b want 0 0", vec_count, done); else passed++;
    for (int i = 1; i <= N_VECTORS; i++) begin
      if (i == 100) begin
        bus.in_valid = 1'b1; bus.x = 6'h3F; bus.y = 6'h01; bus.s = 6'h01; bus.cout = 1'b0;
      end else begin
        set_beat(1, WIDTH'($urandom), WIDTH'($urandom), 0);
      end
      cyc();
      checks++; if (err_pulse !== m_pend_mis) $display("FAIL fault_err_pulse beat %0d got %b want %b", i, err_pulse, m_pend_mis); else passed++;
      if (i == 100) begin
        checks++; if (err_pulse !== 1'b1 || err_count !== '0) $display("FAIL fault_latency got pulse=%b cnt=%0d want pulse=1 cnt=0", err_pulse, err_count); else passed++;
      end
      if (i == 101) begin
        checks++; if (err_count !== 13'd1) $display("FAIL fault_err_count got %0d want 1", err_count); else passed++;
        checks++; if (first_err_idx !== 13'd100) $display("FAIL fault_first_idx got %0d want 100", first_err_idx); else passed++;
      end
    end
    set_beat(0, '0, '0, 0);
    cyc();
    checks++; if (done !== 1'b1 || pass !== 1'b0) $display("FAIL fault_done_pass got done=%b pass=%b want 1 0", done, pass); else passed++;
    checks++; if (err_count !== 13'd1 || first_err_idx !== 13'd100) $display("FAIL fault_final got cnt=%0d idx=%0d want 1 100", err_count, first_err_idx); else passed++;
  endtask

  task automatic test_carry_fault();
    pulse_start();
    bus.in_valid = 1'b1; bus.x = 6'd32; bus.y = 6'd32; bus.s = 6'd0; bus.cout = 1'b0;
    cyc();
    checks++; if (err_pulse !== 1'b1) $display("FAIL carry_missing_flag got %b want 1", err_pulse); else passed++;
    bus.cout = 1'b1;
    cyc();
    checks++; if (err_pulse !== 1'b0) $display("FAIL carry_correct_flag got %b want 0", err_pulse); else passed++;
    checks++; if (err_count !== 13'd1 || first_err_idx !== 13'd1) $display("FAIL carry_counts got cnt=%0d idx=%0d want 1 1", err_count, first_err_idx); else passed++;
    for (int i = 3; i <= N_VECTORS; i++) begin
      set_beat(1, WIDTH'($urandom), WIDTH'($urandom), 0);
      cyc();
      checks++; if (err_pulse !== m_pend_mis) $display("FAIL carry_err_pulse beat %0d got %b want %b", i, err_pulse, m_pend_mis); else passed++;
    end
    set_beat(0, '0, '0, 0);
    cyc();
    checks++; if (done !== 1'b1 || pass !== 1'b0 || err_count !== 13'd1) $display("FAIL carry_final got done=%b pass=%b cnt=%0d want 1 0 1", done, pass, err_count); else passed++;
  endtask

  task automatic test_handshake();
    pulse_start();
    for (int k = 0; k < 30000 && m_acc < N_VECTORS; k++) begin
      set_beat(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 0);
      start = ($urandom_range(0, 15) == 0);
      cyc();
      checks++; if (vec_count !== CNT_W'(m_acc)) $display("FAIL hs_vec_count got %0d want %0d", vec_count, m_acc); else passed++;
      checks++; if (bus.in_ready !== m_ready()) $display("FAIL hs_in_ready got %b want %b", bus.in_ready, m_ready()); else passed++;
    end
    checks++; if (m_acc != N_VECTORS) $display("FAIL hs_timeout got %0d accepts want %0d", m_acc, N_VECTORS); else passed++;
    set_beat(1, '0, '0, 0);
    start = 1'b1;
    checks++; if (done !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL hs_flush got done=%b ready=%b want 0 0", done, bus.in_ready); else passed++;
    cyc();
    start = 1'b0;
    set_beat(0, '0, '0, 0);
    checks++; if (done !== 1'b1 || pass !== 1'b1) $display("FAIL hs_done got done=%b pass=%b want 1 1", done, pass); else passed++;
    checks++; if (vec_count !== CNT_W'(N_VECTORS)) $display("FAIL hs_vec_final got %0d want %0d", vec_count, N_VECTORS); else passed++;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    for (int k = 0; k < 5000 && m_acc < 2000; k++) begin
      set_beat(1, WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 7) == 0));
      cyc();
    end
    checks++; if (vec_count !== 13'd2000) $display("FAIL mid_pre_reset got %0d want 2000", vec_count); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (vec_count !== '0 || err_count !== '0 || first_err_idx !== '0) $display("FAIL mid_async_counts got vec=%0d cnt=%0d idx=%0d want 0 0 0", vec_count, err_count, first_err_idx); else passed++;
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || err_pulse !== 1'b0) $display("FAIL mid_async_flags got busy=%b ready=%b pulse=%b want 0 0 0", busy, bus.in_ready, err_pulse); else passed++;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    pulse_start();
    for (int k = 0; k < 5000 && m_acc < N_VECTORS; k++) begin
      set_beat(1, WIDTH'($urandom), WIDTH'($urandom), 0);
      cyc();
      if (k == 0) begin
        checks++; if (vec_count !== 13'd1) $display("FAIL mid_restart got %0d want 1", vec_count); else passed++;
      end
    end
    set_beat(0, '0, '0, 0);
    cyc();
    checks++; if (done !== 1'b1 || pass !== 1'b1 || vec_count !== CNT_W'(N_VECTORS)) $display("FAIL mid_full_run got done=%b pass=%b vec=%0d", done, pass, vec_count); else passed++;
  endtask

  task automatic test_random_faults();
    pulse_start();
    for (int k = 0; k < 20000 && m_acc < N_VECTORS; k++) begin
      set_beat(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
               ($urandom_range(0, 15) == 0));
      cyc();
      checks++; if (err_pulse !== m_pend_mis) $display("FAIL rnd_err_pulse got %b want %b", err_pulse, m_pend_mis); else passed++;
      checks++; if (err_count !== CNT_W'(m_err)) $display("FAIL rnd_err_count got %0d want %0d", err_count, m_err); else passed++;
      checks++; if (first_err_idx !== CNT_W'(m_first)) $display("FAIL rnd_first_idx got %0d want %0d", first_err_idx, m_first); else passed++;
    end
    set_beat(0, '0, '0, 0);
    checks++; if (err_pulse !== m_pend_mis) $display("FAIL rnd_flush_pulse got %b want %b", err_pulse, m_pend_mis); else passed++;
    cyc();
    checks++; if (done !== 1'b1) $display("FAIL rnd_done got %b want 1", done); else passed++;
    checks++; if (pass !== (m_err == 0)) $display("FAIL rnd_pass got %b want %b", pass, (m_err == 0)); else passed++;
    checks++; if (err_count !== CNT_W'(m_err) || first_err_idx !== CNT_W'(m_first)) $display("FAIL rnd_final got cnt=%0d idx=%0d want %0d %0d", err_count, first_err_idx, m_err, m_first); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_carry_fault();
    test_handshake();
    test_reset_mid_run();
    test_random_faults();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
